// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and field positions for the SPI register sequencer
package spi_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 3;

    // Command byte layout: {rw, len-1[2:0], start_addr[3:0]}
    localparam int CMD_RW_BIT  = 7;
    localparam int CMD_LEN_HI  = 6;
    localparam int CMD_LEN_LO  = 4;
    localparam int CMD_ADDR_HI = 3;
    localparam int CMD_ADDR_LO = 0;

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_TURN  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - bit counter, MOSI receive shifter and MISO transmit shifter
//  spi_clk_i   : SPI clock, all state on posedge
//  rst_i       : synchronous active-high reset
//  spi_mosi_i  : serial input, MSB first
//  tx_load_i   : load tx_data_i into the transmit shifter instead of shifting
//  tx_data_i   : parallel byte for the transmit shifter
//  byte_done_o : high during the cycle whose posedge completes a byte
//  rx_byte_o   : completed byte including the bit sampled on this edge
//  bit_cnt_o   : current bit position 0..7
//  tx_msb_o    : registered MISO bit
module spi_byte_shifter
    import spi_seq_pkg::*;
(
    input  logic              spi_clk_i,
    input  logic              rst_i,
    input  logic              spi_mosi_i,
    input  logic              tx_load_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    output logic              byte_done_o,
    output logic [BYTE_W-1:0] rx_byte_o,
    output logic [CNT_W-1:0]  bit_cnt_o,
    output logic              tx_msb_o
);

    logic [CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0] rx_sr_q;
    logic [BYTE_W-1:0] tx_sr_q;

    always_ff @(posedge spi_clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            rx_sr_q   <= {rx_sr_q[BYTE_W-2:0], spi_mosi_i};
            if (tx_load_i) begin
                tx_sr_q <= tx_data_i;
            end else begin
                tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign byte_done_o = &bit_cnt_q;
    assign rx_byte_o   = {rx_sr_q[BYTE_W-2:0], spi_mosi_i};
    assign bit_cnt_o   = bit_cnt_q;
    assign tx_msb_o    = tx_sr_q[BYTE_W-1];

endmodule

// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - SPI command decoder running burst register reads/writes
//  spi_clk/rst          : clock and synchronous active-high reset
//  spi_mosi/spi_miso    : serial data in/out, MSB first
//  reg_addr             : registered register address
//  reg_wr_en/wr_data    : one-cycle write strobe and its data
//  reg_rd_data          : combinational read of reg_addr
//  busy/txn_done/err    : activity flag, end-of-burst pulse, sticky error
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] RO_MASK  = 16'h0000
) (
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [BYTE_W-1:0] reg_wr_data,
    input  logic [BYTE_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              txn_done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    seq_state_e        state_q, state_d;
    logic [2:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              inc_pend_q, inc_pend_d;

    logic              byte_done;
    logic [BYTE_W-1:0] rx_byte;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tx_load;
    logic [BYTE_W-1:0] tx_data;
    logic              rd_ok;
    logic              wr_ok;

    spi_byte_shifter u_shifter (
        .spi_clk_i   (spi_clk),
        .rst_i       (rst),
        .spi_mosi_i  (spi_mosi),
        .tx_load_i   (tx_load),
        .tx_data_i   (tx_data),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte),
        .bit_cnt_o   (bit_cnt),
        .tx_msb_o    (spi_miso)
    );

    assign rd_ok = addr_valid(addr_q);
    assign wr_ok = addr_valid(addr_q) && !RO_MASK[addr_q];

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            rem_q      <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inc_pend_q <= inc_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        inc_pend_d = 1'b0;
        tx_load    = 1'b0;
        tx_data    = '0;

        // Write bursts hold the address through the strobe cycle, then step.
        if (inc_pend_q) begin
            addr_d = addr_next(addr_q);
        end

        if (byte_done) begin
            // Reloading zero at every non-read boundary keeps MISO low outside RDATA.
            tx_load = 1'b1;
            unique case (state_q)
                ST_CMD: begin
                    rem_d   = rx_byte[CMD_LEN_HI:CMD_LEN_LO];
                    addr_d  = rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
                    state_d = rx_byte[CMD_RW_BIT] ? ST_WDATA : ST_TURN;
                end
                ST_TURN: begin
                    state_d = ST_RDATA;
                    tx_data = rd_ok ? reg_rd_data : '0;
                    if (!rd_ok) err_d = 1'b1;
                    // Reads prefetch: reg_addr points at the byte loaded next.
                    if (rem_q != 3'd0) addr_d = addr_next(addr_q);
                end
                ST_WDATA: begin
                    wr_data_d = rx_byte;
                    if (wr_ok) begin
                        wr_en_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (rem_q == 3'd0) begin
                        state_d = ST_CMD;
                        done_d  = 1'b1;
                    end else begin
                        rem_d      = rem_q - 1'b1;
                        inc_pend_d = 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (rem_q == 3'd0) begin
                        state_d = ST_CMD;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        tx_data = rd_ok ? reg_rd_data : '0;
                        if (!rd_ok) err_d = 1'b1;
                        if (rem_q != 3'd1) addr_d = addr_next(addr_q);
                    end
                end
            endcase
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign txn_done    = done_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_CMD) || (bit_cnt != '0);

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb/tb_spi_reg_sequencer.sv - scoreboard bench for spi_reg_sequencer
module tb_spi_reg_sequencer;

    logic       spi_clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_b = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       rst_a, rst_b;
    logic       miso_a, miso_b, wr_en_a, wr_en_b, done_a, done_b;
    logic       err_a, err_b, busy_a, busy_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic [7:0] bank [16];

    logic       m_miso, m_wr_en, m_done, m_err, m_busy;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_miso_q [$];
    logic [11:0] exp_wr_q   [$];
    bit          exp_done_q [$];

    bit drv_active = 1'b0;
    int drv_bit = 0;

    always #5 spi_clk = ~spi_clk;

    // Instance A: 16 regs, addr 2 read-only. Instance B: 8 regs. Only one runs at a time.
    assign rst_a = rst | sel_b;
    assign rst_b = rst | ~sel_b;
    assign rdata_a = bank[addr_a];
    assign rdata_b = bank[addr_b];

    assign m_miso  = sel_b ? miso_b  : miso_a;
    assign m_wr_en = sel_b ? wr_en_b : wr_en_a;
    assign m_done  = sel_b ? done_b  : done_a;
    assign m_err   = sel_b ? err_b   : err_a;
    assign m_busy  = sel_b ? busy_b  : busy_a;
    assign m_addr  = sel_b ? addr_b  : addr_a;
    assign m_wdata = sel_b ? wdata_b : wdata_a;

    spi_reg_sequencer #(.NUM_REGS(16), .RO_MASK(16'h0004)) u_dut_a (
        .spi_clk     (spi_clk),
        .rst         (rst_a),
        .spi_mosi    (spi_mosi),
        .spi_miso    (miso_a),
        .reg_addr    (addr_a),
        .reg_wr_en   (wr_en_a),
        .reg_wr_data (wdata_a),
        .reg_rd_data (rdata_a),
        .busy        (busy_a),
        .txn_done    (done_a),
        .err         (err_a)
    );

    spi_reg_sequencer #(.NUM_REGS(8), .RO_MASK(16'h0000)) u_dut_b (
        .spi_clk     (spi_clk),
        .rst         (rst_b),
        .spi_mosi    (spi_mosi),
        .spi_miso    (miso_b),
        .reg_addr    (addr_b),
        .reg_wr_en   (wr_en_b),
        .reg_wr_data (wdata_b),
        .reg_rd_data (rdata_b),
        .busy        (busy_b),
        .txn_done    (done_b),
        .err         (err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: MISO framed by the driver's bit index, write strobes, txn_done pulses.
    initial begin
        logic [7:0]  miso_sr;
        logic [7:0]  e8;
        logic [11:0] e12;
        miso_sr = '0;
        for (int i = 0; i < 16; i++) bank[i] = 8'hC0 + 8'(i);
        bank[14] = 8'h11;
        bank[15] = 8'h22;
        bank[0]  = 8'h33;
        forever begin
            @(negedge spi_clk);
            #1;
            if (drv_active) begin
                miso_sr = {miso_sr[6:0], m_miso};
                if (drv_bit == 7) begin
                    if (exp_miso_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL miso_unexpected: actual 0x%0h expected none", miso_sr);
                    end else begin
                        e8 = exp_miso_q.pop_front();
                        check("miso_byte", 32'(miso_sr), 32'(e8));
                    end
                end
            end
            if (m_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: actual addr 0x%0h data 0x%0h expected none", m_addr, m_wdata);
                end else begin
                    e12 = exp_wr_q.pop_front();
                    check("wr_addr_data", 32'({m_addr, m_wdata}), 32'(e12));
                end
                bank[m_addr] = m_wdata;
            end
            if (m_done) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn_done_unexpected: actual 1 expected 0");
                end else begin
                    void'(exp_done_q.pop_front());
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge spi_clk);
            rst        = 1'b0;
            spi_mosi   = b[7-i];
            drv_bit    = i;
            drv_active = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso);
        exp_miso_q.push_back(exp_miso);
        send_bits(b, 8);
    endtask

    task automatic do_reset(input bit use_b);
        @(negedge spi_clk);
        rst        = 1'b1;
        sel_b      = use_b;
        drv_active = 1'b0;
        spi_mosi   = 1'b0;
        @(posedge spi_clk);
        #1;
        check("reset_state", 32'({m_miso, m_addr, m_wr_en, m_wdata, m_done, m_err, m_busy}), 32'd0);
    endtask

    task automatic end_test(input logic exp_err);
        @(negedge spi_clk);
        drv_active = 1'b0;
        spi_mosi   = 1'b0;
        @(negedge spi_clk);
        #2;
        check("err_flag", 32'(m_err), 32'(exp_err));
        check("busy_mid_byte", 32'(m_busy), 32'd1);
        check("miso_q_drained", 32'(exp_miso_q.size()), 32'd0);
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        check("done_q_drained", 32'(exp_done_q.size()), 32'd0);
    endtask

    initial begin
        // Single write: addr 3 <= 0x5A
        do_reset(1'b0);
        exp_wr_q.push_back({4'h3, 8'h5A});
        exp_done_q.push_back(1'b1);
        send_byte(8'h83, 8'h00);
        send_byte(8'h5A, 8'h00);
        end_test(1'b0);

        // Burst read of 3 from 0xE, wrapping F -> 0
        do_reset(1'b0);
        exp_done_q.push_back(1'b1);
        send_byte(8'h2E, 8'h00);
        send_byte(8'hFF, 8'h00);
        send_byte(8'hFF, 8'h11);
        send_byte(8'hFF, 8'h22);
        send_byte(8'hFF, 8'h33);
        end_test(1'b0);

        // Write burst starting at read-only addr 2: only addr 3 written
        do_reset(1'b0);
        exp_wr_q.push_back({4'h3, 8'hBB});
        exp_done_q.push_back(1'b1);
        send_byte(8'h92, 8'h00);
        send_byte(8'hAA, 8'h00);
        send_byte(8'hBB, 8'h00);
        end_test(1'b1);

        // Invalid read of addr 9 on the 8-register instance
        do_reset(1'b1);
        exp_done_q.push_back(1'b1);
        send_byte(8'h09, 8'h00);
        send_byte(8'hFF, 8'h00);
        send_byte(8'hFF, 8'h00);
        end_test(1'b1);

        // Reset at bit 4 of the second write byte, then a fresh command
        do_reset(1'b0);
        exp_wr_q.push_back({4'h3, 8'h44});
        send_byte(8'h93, 8'h00);
        send_byte(8'h44, 8'h00);
        send_bits(8'h55, 4);
        do_reset(1'b0);
        exp_wr_q.push_back({4'h5, 8'h77});
        exp_done_q.push_back(1'b1);
        send_byte(8'h85, 8'h00);
        send_byte(8'h77, 8'h00);
        end_test(1'b0);

        // Back-to-back: write 3 bytes at 6, then read 2 bytes back from 6
        do_reset(1'b0);
        exp_wr_q.push_back({4'h6, 8'h01});
        exp_wr_q.push_back({4'h7, 8'h02});
        exp_wr_q.push_back({4'h8, 8'h03});
        exp_done_q.push_back(1'b1);
        exp_done_q.push_back(1'b1);
        send_byte(8'hA6, 8'h00);
        send_byte(8'h01, 8'h00);
        send_byte(8'h02, 8'h00);
        send_byte(8'h03, 8'h00);
        send_byte(8'h16, 8'h00);
        send_byte(8'hFF, 8'h00);
        send_byte(8'hFF, 8'h01);
        send_byte(8'hFF, 8'h02);
        end_test(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
